// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer for a single-port word-addressed data memory
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int FIXED_PRIO   = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t state_q, state_d;
  logic owner_q, owner_d, we_q, we_d, last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic [3:0] starve_q, starve_d;
  logic p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic tie, win, grant, rd_done, access;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
      starve_q     <= 4'd0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      starve_q     <= starve_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      p0_rvalid_q  <= p0_rvalid_d;
      p1_rvalid_q  <= p1_rvalid_d;
    end
  end

  always_comb begin
    tie          = p0_req && p1_req;
    win          = tie ? (FIXED_PRIO != 0 ? starve_q >= LIMIT : !last_grant_q) : p1_req;
    grant        = state_q == IDLE && (p0_req || p1_req);
    state_d      = grant ? ACCESS : IDLE;
    owner_d      = grant ? win : owner_q;
    we_d         = grant ? (win ? p1_we : p0_we) : we_q;
    addr_d       = grant ? (win ? p1_addr : p0_addr) : addr_q;
    wdata_d      = grant ? (win ? p1_wdata : p0_wdata) : wdata_q;
    last_grant_d = grant ? win : last_grant_q;
    starve_d     = !(FIXED_PRIO != 0 && grant) ? starve_q :
                   win ? 4'd0 :
                   tie && starve_q != 4'hf ? starve_q + 4'd1 : starve_q;
    rd_done      = state_q == ACCESS && !we_q;
    p0_rvalid_d  = rd_done && !owner_q;
    p1_rvalid_d  = rd_done && owner_q;
    p0_rdata_d   = p0_rvalid_d ? mem_rdata : p0_rdata_q;
    p1_rdata_d   = p1_rvalid_d ? mem_rdata : p1_rdata_q;
  end

  always_comb begin
    access    = state_q == ACCESS && reset;
    mem_read  = access && !we_q;
    mem_write = access && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    p0_ack    = access && !owner_q;
    p1_ack    = access && owner_q;
    p0_rdata  = p0_rdata_q;
    p1_rdata  = p1_rdata_q;
    p0_rvalid = p0_rvalid_q;
    p1_rvalid = p1_rvalid_q;
    busy      = state_q != IDLE;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for round-robin and fixed-priority arbiter instances
module tb_dmem_arbiter;
  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic reset, resetb;
  logic p0_req, p0_we, p0_ack, p0_rvalid, p1_req, p1_we, p1_ack, p1_rvalid;
  logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
  logic mem_read, mem_write, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic b_p0_req, b_p1_req, b_we, b_p0_ack, b_p1_ack, b_p0_rvalid, b_p1_rvalid;
  logic [31:0] b_p0_addr, b_p1_addr, b_wdata, b_p0_rdata, b_p1_rdata;
  logic b_mem_read, b_mem_write, b_busy;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [31:0] mem [0:63];
  txn_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  assign mem_rdata   = mem[mem_addr[7:2]];
  assign b_mem_rdata = ~b_mem_addr;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .STARVE_LIMIT(2)) dut_fixed (
    .clk(clk), .reset(resetb),
    .p0_req(b_p0_req), .p0_we(b_we), .p0_addr(b_p0_addr), .p0_wdata(b_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata), .p0_rvalid(b_p0_rvalid),
    .p1_req(b_p1_req), .p1_we(b_we), .p1_addr(b_p1_addr), .p1_wdata(b_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata), .p1_rvalid(b_p1_rvalid),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t = '{port, we, addr, data};
    exp_q.push_back(t);
  endtask

  task automatic wait_ack(input bit port, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? p1_ack : p0_ack) && n < 10);
    chk(port ? "p1_ack_seen" : "p0_ack_seen", {63'd0, port ? p1_ack : p0_ack}, 64'd1);
  endtask

  task automatic xfer(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] data);
    int n;
    push(port, we, addr, data);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = data;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = data;
    end
    wait_ack(port, n);
    chk("ack_latency", 64'(n), 64'd2);
    step();
    if (port) p1_req = 1'b0;
    else p0_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      if (mem_write) mem[mem_addr[7:2]] = mem_wdata;
    end
  end

  initial begin
    txn_t e, rd;
    bit have_rd;
    have_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (have_rd) begin
        chk("rvalid", {62'd0, p1_rvalid, p0_rvalid}, rd.port ? 64'd2 : 64'd1);
        chk("rdata", {32'd0, rd.port ? p1_rdata : p0_rdata}, {32'd0, rd.data});
        have_rd = 1'b0;
      end else if (p0_rvalid || p1_rvalid) begin
        chk("stray_rvalid", {62'd0, p1_rvalid, p0_rvalid}, 64'd0);
      end
      if (p0_ack || p1_ack) begin
        if (exp_q.size() == 0) chk("unexpected_ack", {62'd0, p1_ack, p0_ack}, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("ack_port", {62'd0, p1_ack, p0_ack}, e.port ? 64'd2 : 64'd1);
          chk("mem_rw", {62'd0, mem_write, mem_read}, e.we ? 64'd2 : 64'd1);
          chk("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
          if (e.we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.data});
          else begin
            rd = e;
            have_rd = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int n, got, last;
    bit fix_ord [6];
    fix_ord = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b0; resetb = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_wdata = 32'h55;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    b_p0_req = 1'b0; b_p1_req = 1'b0; b_we = 1'b0; b_wdata = 32'h0;
    b_p0_addr = 32'h40; b_p1_addr = 32'h80;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
      chk("rst_ack", {62'd0, p1_ack, p0_ack}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
    end
    chk("rst_rvalid", {62'd0, p1_rvalid, p0_rvalid}, 64'd0);
    chk("rst_rdata", {p1_rdata, p0_rdata}, 64'd0);
    push(1'b0, 1'b1, 32'h20, 32'h55);
    step();
    reset = 1'b1; resetb = 1'b1;
    wait_ack(1'b0, n);
    chk("first_grant_latency", 64'(n), 64'd2);
    step();
    p0_req = 1'b0;

    xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    xfer(1'b0, 1'b0, 32'h10, 32'hDEADBEEF);

    push(1'b1, 1'b1, 32'h4, 32'h1);
    push(1'b0, 1'b0, 32'h4, 32'h1);
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h4; p1_wdata = 32'h1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h4; p0_wdata = 32'h0;
    wait_ack(1'b1, n);
    chk("coh_p1_latency", 64'(n), 64'd2);
    step();
    p1_req = 1'b0;
    wait_ack(1'b0, n);
    chk("coh_p0_latency", 64'(n), 64'd2);
    step();
    p0_req = 1'b0;

    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h8; p1_wdata = 32'h77;
    step();
    reset = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
    chk("midrst_mem_write", {63'd0, mem_write}, 64'd0);
    chk("midrst_p1_ack", {63'd0, p1_ack}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd1);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {63'd0, busy}, 64'd0);
    step();
    xfer(1'b0, 1'b0, 32'h8, 32'h0);

    xfer(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    repeat (4) push(1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.delete();
    push(1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
    push(1'b1, 1'b0, 32'h4, 32'h1);
    push(1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
    push(1'b1, 1'b0, 32'h4, 32'h1);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h4;
    got = 0; last = 0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        if (got > 0) chk("rr_ack_gap", 64'(cyc - last), 64'd2);
        last = cyc;
        got++;
      end
    end
    chk("rr_grants", 64'(got), 64'd4);
    step();
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) step();

    b_p0_req = 1'b1; b_p1_req = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && got < 6; i++) begin
      @(negedge clk);
      if (b_p0_ack || b_p1_ack) begin
        chk("fix_order", {63'd0, b_p1_ack}, {63'd0, fix_ord[got]});
        chk("fix_mem_addr", {32'd0, b_mem_addr}, b_p1_ack ? 64'h80 : 64'h40);
        got++;
      end
    end
    chk("fix_grants", 64'(got), 64'd6);
    step();
    b_p0_req = 1'b0; b_p1_req = 1'b0;
    repeat (3) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port word-addressed data memory (MemRead/MemWrite/Address/WriteData in, combinational ReadData out).
- Port 0 serves the pipeline MEM stage; port 1 serves a secondary master (program/data loader, debug).
- Latches the winning request, drives one memory access, and returns an acknowledge plus registered read data.

Parameters:
ADDR_W, 32, requester/memory address width (bytes; memory uses addr[ADDR_W-1:2])
DATA_W, 32, data width
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 priority with starvation guard
STARVE_LIMIT, 4, consecutive losing arbitrations after which port 1 is forced a grant (FIXED_PRIO=1 only); legal range 1..15

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
p0_req  in  1  port 0 request, held until p0_ack
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  ADDR_W  port 0 byte address
p0_wdata  in  DATA_W  port 0 write data
p0_ack  out  1  one-cycle pulse: port 0 access performed
p0_rdata  out  DATA_W  port 0 read data, valid with p0_rvalid
p0_rvalid  out  1  one-cycle pulse, read data ready
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_rvalid: as port 0, for port 1
mem_read  out  1  to memory MemRead
mem_write  out  1  to memory MemWrite
mem_addr  out  ADDR_W  to memory Address
mem_wdata  out  DATA_W  to memory WriteData
mem_rdata  in  DATA_W  from memory ReadData (combinational)
busy  out  1  high while state != IDLE

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, all acks/rvalids=0, rdata=0, latched addr/wdata/we=0, owner=0, last_grant=1, starve_cnt=0. mem_read/mem_write are gated low combinationally while reset==0, so no write commits during reset. A reset arriving mid-access abandons it with no ack or rvalid.
- FSM states:
  - IDLE: if any req is high at the edge, arbitrate, latch owner/we/addr/wdata, go to ACCESS; else stay.
  - ACCESS (exactly 1 cycle): mem_addr/mem_wdata come from the latches; mem_write=we, mem_read=!we; owner's ack=1. At the end edge the memory commits a write; for a read, mem_rdata is registered into owner's rdata and owner's rvalid is set for the next cycle. Always returns to IDLE.
- Latency: request seen at edge N. Access and ack occur in cycle N+1. Read data and rvalid appear in cycle N+2, overlapping IDLE. Throughput is one access per 2 cycles per arbiter.
- Requester must drop req in the cycle after ack, otherwise the arbiter treats it as a new request. Changes to we/addr/wdata after the grant edge are ignored.
- Round-robin (FIXED_PRIO=0):
  - single requester wins;
  - on a tie, the port != last_grant wins;
  - last_grant updates on every grant.
- Fixed mode (FIXED_PRIO=1):
  - on a tie, port 0 wins unless starve_cnt >= STARVE_LIMIT, in which case port 1 wins;
  - starve_cnt increments (saturating at 15) whenever port 1 loses a tie;
  - starve_cnt clears on any port 1 grant.
- Outputs of the non-owner port stay 0. rdata holds its last value between reads; only rvalid qualifies it.
- Idle outputs: mem_read=mem_write=0. mem_addr/mem_wdata hold the latched values (don't-care for memory).

Test Plan:
- Reset: hold reset=0 for 3 cycles with p0_req=1 and we=1 -> mem_write stays 0, no ack; after release, first grant goes to port 0 on the edge after reset deasserts.
- Single write then read: p0 writes 0xDEADBEEF to 0x10 -> p0_ack in cycle N+1 with mem_write=1 and mem_addr=0x10; p0 then reads 0x10 -> p0_rvalid at N+2 with p0_rdata=0xDEADBEEF.
- Round-robin tie: p0 and p1 both hold req continuously for 4 grants -> grant order p0, p1, p0, p1, each ack 2 cycles apart.
- Fixed priority starvation with STARVE_LIMIT=2: both ports requesting continuously -> grant order p0, p0, p1, p0, p0, p1.
- Cross-port coherency: p1 writes 0x00000001 to 0x4 while p0 requests a read of 0x4 in the same cycle (round-robin, last_grant=0) -> p1 is served first, then p0_rdata=0x00000001.
- Reset mid-access: assert reset=0 during ACCESS of a p1 write to 0x8 (prior value 0) -> mem_write=0 that cycle, no p1_ack, a later read of 0x8 returns 0, and the FSM is in IDLE after reset.
